// File: rtl/unified_mem_ctrl.sv
// Single-port word memory behind a request/response handshake with a fixed wait-state latency.
// Optional MISALIGN_TRAP_EN: requests with addr[1:0] != 0 complete as faults.
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_cur_we;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_wdata;
  logic [3:0]  w_cur_be;
  logic [AW-1:0] w_idx;
  logic        w_oor;
  logic        w_mis;
  logic        w_fault;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // With zero wait states the accept edge is also the commit edge, so the
  // transaction must be taken straight from the inputs in IDLE.
  assign w_cur_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_cur_be    = (r_state == S_IDLE) ? req_be    : r_be;

  assign w_idx = w_cur_addr[AW+1:2];
  assign w_oor = |w_cur_addr[31:AW+2];

`ifdef MISALIGN_TRAP_EN
  assign w_mis = |w_cur_addr[1:0];
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^w_cur_addr[1:0];
  assign w_mis = 1'b0;
`endif

  assign w_fault      = w_oor || w_mis;
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt <= 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE) && !rst;
    rsp_valid = (r_state == S_RESP);
    rsp_rdata = rsp_valid ? r_rdata : 32'd0;
    rsp_err   = rsp_valid && r_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_cnt <= 4'd0;
    else if (w_accept)         r_cnt <= WAIT_INIT;
    else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // Read-before-write on the commit edge; the rst guard keeps an aborted store out of memory.
  always_ff @(posedge clk) begin
    if (w_enter_resp && !rst) begin
      r_err   <= w_fault;
      r_rdata <= (!w_cur_we && !w_fault) ? r_mem[w_idx] : 32'd0;
      if (w_cur_we && !w_fault) begin
        for (int i = 0; i < 4; i++) begin
          if (w_cur_be[i]) r_mem[w_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Testbench for unified_mem_ctrl: transaction-level reference model checked every cycle,
// directed literal checks, then randomized traffic with occasional resets.
module tb_unified_mem_ctrl;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  unified_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  int cyc;

  // Reference model: memory image plus at most one outstanding transaction.
  logic [31:0] mem_m [DEPTH];
  logic        p_on;
  logic        p_we;
  logic        p_err;
  logic [7:0]  p_idx;
  logic [31:0] p_wd;
  logic [3:0]  p_be;
  int          p_due;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic fault_of(input logic [31:0] a);
    logic f;
    f = ({2'b00, a[31:2]} >= 32'(DEPTH));
`ifdef MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  task automatic monitor();
    logic [31:0] ed;
    logic ev, ee, er, busy;
    forever begin
      @(negedge clk);
      cyc++;
      busy = p_on;
      ev = 1'b0; ed = 32'd0; ee = 1'b0;
      if (p_on && p_due == cyc) begin
        if (!p_we && !p_err) ed = mem_m[p_idx];
        if (p_we && !p_err)
          for (int i = 0; i < 4; i++)
            if (p_be[i]) mem_m[p_idx][8*i +: 8] = p_wd[8*i +: 8];
        ev = 1'b1;
        ee = p_err;
        if (rst) begin ev = 1'b0; ed = 32'd0; ee = 1'b0; end
        p_on = 1'b0;
      end
      if (rst) p_on = 1'b0;
      er = !rst && !busy;
      chk("req_ready", {31'd0, req_ready}, {31'd0, er});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
      chk("rsp_rdata", rsp_rdata, ed);
      chk("rsp_err",   {31'd0, rsp_err},   {31'd0, ee});
      if (req_valid && er) begin
        p_on  = 1'b1;
        p_due = cyc + 1 + W;
        p_we  = req_we;
        p_idx = req_addr[9:2];
        p_wd  = req_wdata;
        p_be  = req_be;
        p_err = fault_of(req_addr);
      end
    end
  endtask

  // Called at posedge+2; returns at posedge+2 of the IDLE cycle after the response.
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd, output logic e,
                     output int lat);
    int n;
    logic got;
    rd = 32'd0; e = 1'b0; lat = 0; got = 1'b0;
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
    if (!req_ready) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout: req_ready still 0 after %0d cycles, expected 1", n);
      req_valid = 1'b0;
      @(posedge clk); #2;
      return;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; e = rsp_err; end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL rsp_timeout: rsp_valid 0 for %0d cycles, expected 1", lat);
    end
    @(posedge clk); #2;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic        seen;
  int          rcnt;
  logic [29:0] wrd;
  logic [1:0]  lo;

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; p_on = 1'b0; rcnt = 0;
    p_we = 1'b0; p_err = 1'b0; p_idx = 8'd0; p_wd = 32'd0; p_be = 4'd0; p_due = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #2;

    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, 32'(i) << 2, 32'hC0DE0000 + 32'(i), 4'hF, rd, e, lat);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", {31'd0, e}, 32'd0);

    txn(1'b1, 32'h10, 32'h000000AA, 4'h1, rd, e, lat);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    chk("be_merge", rd, 32'hDEADBEAA);
    chk("model_w4", mem_m[4], 32'hDEADBEAA);

    txn(1'b0, 32'h400, 32'h0, 4'h0, rd, e, lat);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    chk("w0_after_oor", rd, 32'hC0DE0000);

    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= rsp_valid; @(posedge clk); end
    #2 rst = 1'b0;
    repeat (4) begin @(negedge clk); seen |= rsp_valid; end
    @(posedge clk); #2;
    chk("abort_no_rsp", {31'd0, seen}, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    chk("abort_prestore", rd, 32'hC0DE0008);

    txn(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
`else
    chk("mis_err", {31'd0, e}, 32'd0);
    chk("mis_rdata", rd, 32'hDEADBEAA);
`endif

    for (int k = 0; k < 3000; k++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom);
      if ($urandom_range(0, 9) == 0) wrd = 30'($urandom);
      else                           wrd = 30'($urandom_range(0, DEPTH - 1));
      lo = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      req_addr  = {wrd, lo};
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      if (rcnt > 0) rcnt--;
      else if ($urandom_range(0, 99) == 0) rcnt = $urandom_range(1, 2);
      rst = (rcnt > 0);
      @(posedge clk); #2;
    end
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
